// File: rtl/common.sv
// Shared data-bus definitions: access sizes, request/response records and an
// alignment helper used by any stage that talks to the data bus.
package common;

  localparam int AXI_WORD_BYTES = 8;
  localparam int DATA_W         = 8 * AXI_WORD_BYTES;
  localparam int ADDR_W         = 64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic                      valid;
    logic [ADDR_W-1:0]         addr;
    msize_t                    size;
    logic [AXI_WORD_BYTES-1:0] strobe;
    logic [DATA_W-1:0]         data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic misaligned(logic [2:0] lo, msize_t size);
    case (size)
      MSIZE1:  return 1'b0;
      MSIZE2:  return lo[0];
      MSIZE4:  return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/pipes.sv
// Inter-stage pipeline records for the execute -> memory -> writeback path.
package pipes;

  import common::*;

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   memext;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    control_t    ctl;
    logic [63:0] aluout;
    logic [63:0] srcb;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    control_t    ctl;
    logic [63:0] result;
    logic        misalign;
  } memory_data_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_stage_memalign.sv
// Byte-lane steering for the data bus: shifts store data/strobes into the
// addressed lanes and pulls load data back out with sign/zero extension.
module memalign
  import common::*;
#(
  parameter int  AXI_WORD_BYTES = 8,
  localparam int LANE_BITS      = $clog2(AXI_WORD_BYTES)
) (
  input  logic [LANE_BITS-1:0]      st_lane,
  input  msize_t                    st_size,
  input  logic [63:0]               wdata,
  output logic [AXI_WORD_BYTES-1:0] strobe,
  output logic [63:0]               wdata_lane,
  input  logic [LANE_BITS-1:0]      ld_lane,
  input  msize_t                    ld_size,
  input  logic                      ld_ext,
  input  logic [63:0]               rdata,
  output logic [63:0]               rdata_ext
);

  logic [AXI_WORD_BYTES-1:0] strobe_base;
  logic [63:0]               rdata_shift;

  // NOTE: every output of a combinational block gets a value on every path;
  // the default-first pattern below keeps synthesis from inferring latches.
  always_comb begin
    strobe_base = '0;
    case (st_size)
      MSIZE1:  strobe_base = 8'h01;
      MSIZE2:  strobe_base = 8'h03;
      MSIZE4:  strobe_base = 8'h0F;
      default: strobe_base = 8'hFF;
    endcase
    strobe     = strobe_base << st_lane;
    wdata_lane = wdata << {st_lane, 3'b000};
  end

  always_comb begin
    rdata_shift = rdata >> {ld_lane, 3'b000};
    rdata_ext   = rdata_shift;
    case (ld_size)
      MSIZE1: rdata_ext = ld_ext ? {56'b0, rdata_shift[7:0]}
                                 : {{56{rdata_shift[7]}}, rdata_shift[7:0]};
      MSIZE2: rdata_ext = ld_ext ? {48'b0, rdata_shift[15:0]}
                                 : {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      MSIZE4: rdata_ext = ld_ext ? {32'b0, rdata_shift[31:0]}
                                 : {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      default: rdata_ext = rdata_shift;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-bus load/store per record, stalls
// upstream until the response arrives, and registers the writeback record.
module memory_stage
  import common::*;
  import pipes::*;
#(
  parameter int  AXI_WORD_BYTES = 8,
  localparam int LANE_BITS      = $clog2(AXI_WORD_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM
);

  mem_state_t state, state_next;

  // Request context captured on entry to MEM_REQ and held until data_ok.
  logic [63:0]               cap_pc;
  logic [31:0]               cap_raw_instr;
  logic [4:0]                cap_dst;
  control_t                  cap_ctl;
  logic [63:0]               cap_addr;
  logic [AXI_WORD_BYTES-1:0] cap_strobe;
  logic [63:0]               cap_data;

  memory_data_t dataM_next;
  logic         capture;
  logic         is_mem;
  logic         is_misaligned;

  logic [AXI_WORD_BYTES-1:0] st_strobe;
  logic [63:0]               st_data;
  logic [63:0]               ld_result;

  memalign #(.AXI_WORD_BYTES(AXI_WORD_BYTES)) u_memalign (
    .st_lane    (dataE.aluout[LANE_BITS-1:0]),
    .st_size    (dataE.ctl.msize),
    .wdata      (dataE.srcb),
    .strobe     (st_strobe),
    .wdata_lane (st_data),
    .ld_lane    (cap_addr[LANE_BITS-1:0]),
    .ld_size    (cap_ctl.msize),
    .ld_ext     (cap_ctl.memext),
    .rdata      (dresp.data),
    .rdata_ext  (ld_result)
  );

  assign is_mem        = dataE.ctl.memread | dataE.ctl.memwrite;
  assign is_misaligned = misaligned(dataE.aluout[2:0], dataE.ctl.msize);

  always_comb begin
    state_next = state;
    dataM_next = '0;
    stallM     = 1'b0;
    capture    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (dataE.valid) begin
          dataM_next.pc        = dataE.pc;
          dataM_next.raw_instr = dataE.raw_instr;
          dataM_next.dst       = dataE.dst;
          dataM_next.ctl       = dataE.ctl;
          if (!is_mem) begin
            dataM_next.valid  = 1'b1;
            dataM_next.result = dataE.aluout;
          end else if (is_misaligned) begin
            dataM_next.valid    = 1'b1;
            dataM_next.misalign = 1'b1;
          end else begin
            // Bubble while the bus op is outstanding; the record is rebuilt
            // from the captured context when data_ok arrives.
            dataM_next = '0;
            capture    = 1'b1;
            stallM     = 1'b1;
            state_next = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        stallM = 1'b1;
        if (dresp.data_ok) begin
          stallM               = 1'b0;
          state_next           = MEM_IDLE;
          dataM_next.valid     = 1'b1;
          dataM_next.pc        = cap_pc;
          dataM_next.raw_instr = cap_raw_instr;
          dataM_next.dst       = cap_dst;
          dataM_next.ctl       = cap_ctl;
          dataM_next.result    = cap_ctl.memread ? ld_result : cap_addr;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEM_IDLE;
      dataM <= '0;
      // NOTE: the capture registers are reset too, so dreq fields are all-zero
      // out of reset rather than X, even though dreq.valid already gates them.
      cap_pc        <= '0;
      cap_raw_instr <= '0;
      cap_dst       <= '0;
      cap_ctl       <= '0;
      cap_addr      <= '0;
      cap_strobe    <= '0;
      cap_data      <= '0;
    end else begin
      state <= state_next;
      dataM <= dataM_next;
      if (capture) begin
        cap_pc        <= dataE.pc;
        cap_raw_instr <= dataE.raw_instr;
        cap_dst       <= dataE.dst;
        cap_ctl       <= dataE.ctl;
        cap_addr      <= dataE.aluout;
        cap_strobe    <= dataE.ctl.memwrite ? st_strobe : '0;
        cap_data      <= dataE.ctl.memwrite ? st_data : '0;
      end
    end
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = (state == MEM_REQ);
    dreq.addr   = cap_addr;
    dreq.size   = cap_ctl.msize;
    dreq.strobe = cap_strobe;
    dreq.data   = cap_data;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected writeback records go into a
// scoreboard queue and a negedge monitor checks each dataM as it appears.
module tb_memory_stage;
  import common::*;
  import pipes::*;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] result;
    logic        misalign;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stallM;

  int   checks = 0;
  int   errors = 0;
  int   seen   = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  memory_stage #(.AXI_WORD_BYTES(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataE  (dataE),
    .dreq   (dreq),
    .dresp  (dresp),
    .dataM  (dataM),
    .stallM (stallM)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [63:0] aluout,
                       input logic [63:0] srcb, input logic rd, input logic wr,
                       input msize_t sz, input logic ext);
    dataE              = '0;
    dataE.valid        = 1'b1;
    dataE.pc           = pc;
    dataE.raw_instr    = pc[31:0] ^ 32'h0000_0013;
    dataE.dst          = pc[6:2];
    dataE.ctl.memread  = rd;
    dataE.ctl.memwrite = wr;
    dataE.ctl.msize    = sz;
    dataE.ctl.memext   = ext;
    dataE.aluout       = aluout;
    dataE.srcb         = srcb;
  endtask

  task automatic expect_wb(input logic [63:0] pc, input logic [63:0] result, input logic mis);
    exp_t x;
    x.pc       = pc;
    x.result   = result;
    x.misalign = mis;
    sb.push_back(x);
  endtask

  // Monitor: every valid dataM must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dataM.valid === 1'b1) begin
      seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dataM actual pc=%h result=%h expected none", dataM.pc, dataM.result);
      end else begin
        e = sb.pop_front();
        check("dataM_pc", dataM.pc, e.pc);
        check("dataM_result", dataM.result, e.result);
        check("dataM_misalign", {63'b0, dataM.misalign}, {63'b0, e.misalign});
      end
    end
  end

  initial begin
    reset = 1'b1;
    dataE = '0;
    dresp = '0;
    step();
    step();
    @(negedge clk);
    check("reset_dataM_valid", {63'b0, dataM.valid}, 64'd0);
    check("reset_dataM_zero", dataM.result, 64'd0);
    check("reset_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    check("reset_stall", {63'b0, stallM}, 64'd0);
    step();
    reset = 1'b0;

    // ALU op: one-cycle pass-through, no stall, no bus activity.
    issue(64'h100, 64'h1234, 64'h0, 1'b0, 1'b0, MSIZE8, 1'b0);
    expect_wb(64'h100, 64'h1234, 1'b0);
    @(negedge clk);
    check("alu_stall", {63'b0, stallM}, 64'd0);
    check("alu_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    step();
    dataE.valid = 1'b0;
    @(negedge clk);
    check("alu_dreq_valid_after", {63'b0, dreq.valid}, 64'd0);
    step();

    // Signed byte load from lane 3, response on the third REQ cycle.
    issue(64'h104, 64'h8000_0003, 64'h0, 1'b1, 1'b0, MSIZE1, 1'b0);
    expect_wb(64'h104, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    @(negedge clk);
    check("lb_stall_entry", {63'b0, stallM}, 64'd1);
    check("lb_dreq_idle", {63'b0, dreq.valid}, 64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      dresp.addr_ok = (i == 0);
      // A held-but-different dataE during the stall must not disturb the request.
      dataE.aluout  = 64'hDEAD_BEEF_0000_0005;
      dataE.valid   = (i < 2);
      if (i == 2) begin
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h1122_3344_8066_5544;
      end
      @(negedge clk);
      check("lb_dreq_valid", {63'b0, dreq.valid}, 64'd1);
      check("lb_dreq_addr", dreq.addr, 64'h8000_0003);
      check("lb_dreq_size", {62'b0, dreq.size}, {62'b0, MSIZE1});
      check("lb_dreq_strobe", {56'b0, dreq.strobe}, 64'd0);
      check("lb_stall", {63'b0, stallM}, (i == 2) ? 64'd0 : 64'd1);
      step();
    end
    dresp = '0;
    dataE = '0;
    @(negedge clk);
    check("lb_dreq_drop", {63'b0, dreq.valid}, 64'd0);
    check("lb_stall_drop", {63'b0, stallM}, 64'd0);
    step();

    // Halfword store to lane 6.
    issue(64'h108, 64'h8000_0006, 64'hABCD, 1'b0, 1'b1, MSIZE2, 1'b0);
    expect_wb(64'h108, 64'h8000_0006, 1'b0);
    @(negedge clk);
    check("sh_stall_entry", {63'b0, stallM}, 64'd1);
    step();
    dataE.valid = 1'b0;
    @(negedge clk);
    check("sh_dreq_valid", {63'b0, dreq.valid}, 64'd1);
    check("sh_dreq_strobe", {56'b0, dreq.strobe}, 64'h00C0);
    check("sh_dreq_data", dreq.data, 64'hABCD_0000_0000_0000);
    check("sh_dreq_size", {62'b0, dreq.size}, {62'b0, MSIZE2});
    check("sh_stall", {63'b0, stallM}, 64'd1);
    step();
    dresp.data_ok = 1'b1;
    @(negedge clk);
    check("sh_stall_dataok", {63'b0, stallM}, 64'd0);
    check("sh_dreq_dataok", {63'b0, dreq.valid}, 64'd1);
    step();
    dresp = '0;
    @(negedge clk);
    check("sh_dreq_drop", {63'b0, dreq.valid}, 64'd0);
    step();

    // Misaligned word load: flagged without any bus request.
    issue(64'h10C, 64'h8000_0002, 64'h0, 1'b1, 1'b0, MSIZE4, 1'b0);
    expect_wb(64'h10C, 64'h0, 1'b1);
    @(negedge clk);
    check("mis_stall", {63'b0, stallM}, 64'd0);
    check("mis_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    step();
    dataE.valid = 1'b0;
    @(negedge clk);
    check("mis_dreq_valid_after", {63'b0, dreq.valid}, 64'd0);
    step();

    // Zero-wait unsigned word load, followed straight away by an ALU op.
    issue(64'h110, 64'h8000_0010, 64'h0, 1'b1, 1'b0, MSIZE4, 1'b1);
    expect_wb(64'h110, 64'h0000_0000_FFFF_FFFF, 1'b0);
    @(negedge clk);
    check("zw_stall_entry", {63'b0, stallM}, 64'd1);
    step();
    dataE.valid   = 1'b0;
    dresp.addr_ok = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h1234_5678_FFFF_FFFF;
    @(negedge clk);
    check("zw_dreq_valid", {63'b0, dreq.valid}, 64'd1);
    check("zw_stall_dataok", {63'b0, stallM}, 64'd0);
    step();
    dresp = '0;
    issue(64'h114, 64'h55, 64'h0, 1'b0, 1'b0, MSIZE8, 1'b0);
    expect_wb(64'h114, 64'h55, 1'b0);
    @(negedge clk);
    check("zw_next_stall", {63'b0, stallM}, 64'd0);
    step();
    dataE = '0;
    @(negedge clk);
    step();

    // Reset in the second REQ cycle aborts the load.
    issue(64'h118, 64'h8000_0020, 64'h0, 1'b1, 1'b0, MSIZE8, 1'b0);
    step();
    dataE.valid = 1'b0;
    @(negedge clk);
    check("rst_req1_valid", {63'b0, dreq.valid}, 64'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_req2_valid", {63'b0, dreq.valid}, 64'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    check("rst_stall", {63'b0, stallM}, 64'd0);
    check("rst_dataM_valid", {63'b0, dataM.valid}, 64'd0);
    step();
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hCAFE_F00D_CAFE_F00D;
    step();
    dresp = '0;
    repeat (3) step();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("dataM_count", 64'(seen), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer of the execute stage's `execute_data_t` record.
- Performs the load/store for that record over the data bus (`dbus_req_t`/`dbus_resp_t` from `common`).
- Aligns and extends load data, and produces the registered `memory_data_t` record for writeback.
- Asserts a stall back to the pipeline while a bus transaction is outstanding.

Parameters:
- AXI_WORD_BYTES, 8, data bus width in bytes; fixes the strobe width and the low address bits used for lane selection.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- dataE  input  execute_data_t  record from execute. Uses valid, pc, raw_instr, dst, ctl, aluout (effective address or ALU result), srcb (store data).
- dreq  output  dbus_req_t  data bus request: valid, addr, size, strobe, data.
- dresp  input  dbus_resp_t  data bus response: addr_ok, data_ok, data.
- dataM  output  memory_data_t  registered record to writeback: valid, pc, raw_instr, dst, ctl, result, misalign.
- stallM  output  1  high while this stage cannot accept a new dataE.

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - FSM goes to IDLE.
  - dataM cleared to all-zero, with valid=0.
  - dreq.valid=0; stallM=0.
- FSM states:
  - IDLE, when dataE.valid=1:
    - Non-memory op (ctl.memread=0 and ctl.memwrite=0): register dataM next edge with result=aluout, valid=1. Latency 1 cycle; no stall.
    - Memory op, aligned: go to REQ. stallM=1 combinationally in that same cycle.
    - Memory op, misaligned (addr[0] for half, addr[1:0] for word, addr[2:0] for double nonzero): no bus request. Register dataM with misalign=1, result=0, valid=1.
  - IDLE, when dataE.valid=0: register dataM.valid=0.
  - REQ:
    - dreq.valid=1; dreq fields held stable from entry until data_ok.
    - Stays in REQ until dresp.data_ok=1. addr_ok is ignored apart from being accepted in any cycle.
    - On data_ok: register dataM (load: aligned/extended data; store: result=aluout), valid=1.
    - Same edge: dreq.valid drops, FSM returns to IDLE, stallM deasserts.
    - stallM=1 throughout REQ, except in the data_ok cycle, where stallM=0 so upstream advances and the next dataE is sampled in IDLE next cycle.
  - While in REQ, dataM.valid=0 (bubble).
- Request encoding (addr = aluout):
  - size from ctl.msize: MSIZE1/2/4/8.
  - Store: data = srcb shifted left by 8*addr[2:0]. strobe = (1/3/15/255) << addr[2:0].
  - Load: strobe=0.
- Load data:
  - Select lane dresp.data >> 8*addr[2:0].
  - Truncate to msize.
  - Sign-extend to 64 bits unless ctl.memext (zero-extend).
- Simultaneous events:
  - data_ok in the first REQ cycle is legal: 1-cycle memory op, dataM valid at edge 2.
  - reset during REQ aborts: dreq.valid drops next cycle and no dataM is produced.
- The captured request (addr, size, ctl, etc.) is registered at REQ entry. dataE changes during stall do not affect it.

Decomposition:
- Package `pipes`:
  - `memory_data_t`.
  - control_t fields memread, memwrite, msize (`msize_t` enum), memext.
- Package `common`:
  - `dbus_req_t`, `dbus_resp_t`, `msize_t` constants.
- Sub-module `memalign`: combinational.
  - Store path: {addr[2:0], msize, wdata} -> {strobe, shifted data}.
  - Load path: {addr[2:0], msize, memext, rdata} -> extended result.
- The FSM and registers stay in memory_stage.

Test Plan:
- ALU op: dataE.valid=1, memread=0, aluout=0x1234 -> next cycle dataM.valid=1, result=0x1234, stallM never high, dreq.valid stays 0.
- Load byte signed, 3-cycle memory: addr=0x80000003, MSIZE1, memext=0, memory data byte3=0x80.
  - Required: dreq.valid=1, size=MSIZE1, strobe=0 for 3 cycles; stallM high until the data_ok cycle.
  - Then dataM.result=0xFFFFFFFFFFFFFF80.
- Store half: addr=0x...6, srcb=0xABCD -> dreq.strobe=0xC0, dreq.data[63:48]=0xABCD; on data_ok dataM.valid=1, result=addr.
- Misaligned word load: addr=0x...2, MSIZE4 -> dreq.valid never asserted; next cycle dataM.valid=1, misalign=1.
- Zero-wait load: data_ok in the first REQ cycle, MSIZE4, memext=1, data word0=0xFFFFFFFF.
  - Required: dataM.result=0x00000000FFFFFFFF two edges after dataE.
  - Next dataE is accepted immediately after.
- Reset mid-REQ: assert reset in the second REQ cycle -> next cycle dreq.valid=0, stallM=0, dataM.valid=0; no later dataM from the aborted load.
